// File: rtl/cont_mod.sv
// Parametrised modulo-N up/down counter with wrap, saturate and one-shot modes.
// tc is combinational so that chained stages can use it directly as their enable.
module cont_mod #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             up,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL      = WIDTH'(MODULUS - 1);
    localparam logic [1:0]       MODE_SAT     = 2'b01;
    localparam logic [1:0]       MODE_ONESHOT = 2'b10;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             done_nxt;
    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] stepped;
    logic             at_term;
    logic             oneshot;

    assign terminal = up ? MAX_VAL : '0;
    assign at_term  = (cnt == terminal);
    assign oneshot  = (mode == MODE_ONESHOT);
    // Only reached away from the terminal, so this step never leaves 0..MODULUS-1.
    assign stepped  = up ? cnt + WIDTH'(1) : cnt - WIDTH'(1);

    // In one-shot mode the counter is only live while running.
    assign tc   = en & ~clr & ~load & at_term & (~oneshot | (state == RUN));
    assign busy = (state == RUN);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        cnt_nxt   = cnt;
        done_nxt  = done;
        state_nxt = state;
        if (clr) begin
            cnt_nxt   = '0;
            done_nxt  = 1'b0;
            state_nxt = IDLE;
        end else if (load) begin
            cnt_nxt   = (din > MAX_VAL) ? MAX_VAL : din;
            done_nxt  = 1'b0;
            state_nxt = oneshot ? RUN : IDLE;
        end else if (!oneshot) begin
            // Leaving one-shot abandons any run or finished state on this same edge.
            state_nxt = IDLE;
            done_nxt  = 1'b0;
            if (en) begin
                if (!at_term) begin
                    cnt_nxt = stepped;
                end else if (mode != MODE_SAT) begin
                    cnt_nxt = up ? '0 : MAX_VAL;
                end
            end
        end else begin
            unique case (state)
                RUN: begin
                    if (en) begin
                        if (at_term) begin
                            done_nxt  = 1'b1;
                            state_nxt = DONE;
                        end else begin
                            cnt_nxt = stepped;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so all of them update together.
        if (!reset) begin
            cnt   <= '0;
            done  <= 1'b0;
            state <= IDLE;
        end else begin
            cnt   <= cnt_nxt;
            done  <= done_nxt;
            state <= state_nxt;
        end
    end

endmodule

// File: tb/tb_cont_mod.sv
// Self-checking bench for cont_mod: directed scenarios, randomized traffic against an
// arithmetic reference model, and a two-stage decimal cascade.
module tb_cont_mod;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk;
    logic         reset;
    logic         en, clr, load, up;
    logic [W-1:0] din;
    logic [1:0]   mode;
    logic [W-1:0] cnt;
    logic         tc, done, busy;

    logic         c_en;
    logic [W-1:0] c0_cnt, c1_cnt;
    logic         c0_tc, c1_tc, c0_done, c1_done, c0_busy, c1_busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: count value, one-shot running flag, done flag.
    int m_cnt;
    bit m_run;
    bit m_done;

    cont_mod #(.WIDTH(W), .MODULUS(M)) dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load), .din(din),
        .up(up), .mode(mode), .cnt(cnt), .tc(tc), .done(done), .busy(busy)
    );

    cont_mod #(.WIDTH(W), .MODULUS(M)) stage0 (
        .clk(clk), .reset(reset), .en(c_en), .clr(1'b0), .load(1'b0), .din(4'd0),
        .up(1'b1), .mode(2'b00), .cnt(c0_cnt), .tc(c0_tc), .done(c0_done), .busy(c0_busy)
    );

    cont_mod #(.WIDTH(W), .MODULUS(M)) stage1 (
        .clk(clk), .reset(reset), .en(c0_tc), .clr(1'b0), .load(1'b0), .din(4'd0),
        .up(1'b1), .mode(2'b00), .cnt(c1_cnt), .tc(c1_tc), .done(c1_done), .busy(c1_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_run  = 1'b0;
        m_done = 1'b0;
    endtask

    // One clock cycle: apply inputs, check tc before the edge, then cnt/done/busy after it.
    task automatic step(input bit e, input bit c, input bit l, input int d,
                        input bit u, input int md, input string tag);
        int  term;
        bit  exp_tc;
        bit  os;
        en   = e;
        clr  = c;
        load = l;
        din  = d[W-1:0];
        up   = u;
        mode = md[1:0];
        #1;
        term   = u ? M - 1 : 0;
        os     = (md == 2);
        exp_tc = e && !c && !l && (m_cnt == term) && !(os && !m_run);
        chk({tag, ".tc"}, tc, exp_tc);
        if (c) begin
            model_reset();
        end else if (l) begin
            m_cnt  = (d > M - 1) ? M - 1 : d;
            m_done = 1'b0;
            m_run  = os;
        end else if (!os) begin
            m_run  = 1'b0;
            m_done = 1'b0;
            if (e) begin
                if (md == 1)
                    m_cnt = u ? ((m_cnt + 1 > M - 1) ? M - 1 : m_cnt + 1)
                              : ((m_cnt - 1 < 0) ? 0 : m_cnt - 1);
                else
                    m_cnt = (m_cnt + (u ? 1 : M - 1)) % M;
            end
        end else if (m_run && e) begin
            if (m_cnt == term) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end else begin
                m_cnt = u ? m_cnt + 1 : m_cnt - 1;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".cnt"}, cnt, m_cnt);
        chk({tag, ".done"}, done, m_done);
        chk({tag, ".busy"}, busy, m_run);
    endtask

    // Assert reset between edges and check outputs clear without a clock.
    task automatic async_reset(input string tag);
        reset = 1'b0;
        #2;
        model_reset();
        chk({tag, ".cnt"}, cnt, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".busy"}, busy, 0);
        en   = 1'b0;
        load = 1'b0;
        clr  = 1'b0;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int md;
        reset = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        load  = 1'b0;
        din   = '0;
        up    = 1'b1;
        mode  = 2'b00;
        c_en  = 1'b0;
        model_reset();
        #2;
        chk("por.cnt", cnt, 0);
        chk("por.done", done, 0);
        chk("por.busy", busy, 0);
        chk("por.tc", tc, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Wrap up through 9 -> 0, then down through 0 -> 9.
        for (int i = 0; i < 11; i++) step(1, 0, 0, 0, 1, 0, "wrap_up");
        chk("wrap_up.end", cnt, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, "wrap_dn");
        chk("wrap_dn.end", cnt, 8);
        step(1, 0, 0, 0, 0, 3, "mode11");
        chk("mode11.end", cnt, 7);
        step(0, 0, 0, 0, 1, 0, "hold");

        // Saturate at 9, then clamped load.
        step(0, 0, 1, 7, 1, 1, "sat_ld");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 1, "sat_up");
        chk("sat.end", cnt, 9);
        step(1, 0, 1, 15, 1, 1, "sat_clamp");
        chk("sat_clamp.val", cnt, 9);
        step(0, 0, 1, 0, 0, 1, "sat_ld0");
        step(1, 0, 0, 0, 0, 1, "sat_dn0");
        chk("sat_dn0.val", cnt, 0);

        // One-shot down from 3.
        step(1, 0, 1, 3, 0, 2, "os_ld");
        chk("os_ld.busy", busy, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 2, "os_run");
        step(1, 0, 0, 0, 0, 2, "os_fin");
        chk("os_fin.done", done, 1);
        chk("os_fin.busy", busy, 0);
        chk("os_fin.cnt", cnt, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 2, "os_after");
        step(0, 0, 1, 5, 0, 2, "os_reld");
        chk("os_reld.done", done, 0);
        chk("os_reld.busy", busy, 1);
        step(1, 0, 1, 0, 0, 2, "os_ld_term");
        step(1, 0, 0, 0, 0, 2, "os_term_fin");
        chk("os_term_fin.done", done, 1);
        step(0, 0, 0, 0, 1, 0, "os_modechg");
        chk("os_modechg.done", done, 0);

        // Priority: clr beats load beats count.
        step(0, 0, 1, 4, 1, 0, "pri_ld4");
        step(1, 1, 1, 8, 1, 0, "pri_clr");
        chk("pri_clr.val", cnt, 0);
        step(1, 0, 1, 8, 1, 0, "pri_ld");
        chk("pri_ld.val", cnt, 8);

        // Asynchronous reset mid-count and mid-one-shot.
        step(0, 0, 1, 6, 1, 0, "rst_ld");
        step(1, 0, 0, 0, 1, 0, "rst_cnt");
        chk("rst_cnt.val", cnt, 7);
        async_reset("rst_mid");
        step(1, 0, 1, 9, 0, 2, "rst_osld");
        step(1, 0, 0, 0, 0, 2, "rst_osrun");
        chk("rst_osrun.busy", busy, 1);
        async_reset("rst_os");

        // Randomized traffic against the model.
        md = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) md = $urandom_range(0, 3);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 15),
                 $urandom_range(0, 3) != 0, md, "rnd");
        end

        // Decimal cascade: stage1 advances only on stage0 9 -> 0.
        en = 1'b0; clr = 1'b0; load = 1'b0;
        chk("casc.init0", c0_cnt, 0);
        chk("casc.init1", c1_cnt, 0);
        k = 0;
        for (int i = 0; i < 25; i++) begin
            c_en = 1'b1;
            #1;
            chk("casc.tc0", c0_tc, (k % M) == M - 1);
            @(posedge clk);
            #1;
            k++;
            chk("casc.s0", c0_cnt, k % M);
            chk("casc.s1", c1_cnt, (k / M) % M);
        end
        c_en = 1'b0;
        chk("casc.end0", c0_cnt, 5);
        chk("casc.end1", c1_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
